// File: rtl/wb_dest_tracker_if.sv
// wb_dest_tracker_if: ID-stage inputs and per-stage destination/hazard outputs of the destination tracker
interface wb_dest_tracker_if #(
    parameter int STALL_CNT_W = 16
);
    logic [31:0]            ID_inst;
    logic                   ID_valid;
    logic                   flush_id;
    logic                   ext_stall;
    logic                   stall;
    logic [4:0]             EXE_wraddr;
    logic                   EXE_wr_en;
    logic                   EXE_is_load;
    logic [4:0]             MEM_wraddr;
    logic                   MEM_wr_en;
    logic                   MEM_is_load;
    logic [4:0]             WB_wraddr;
    logic                   WB_wr_en;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output ID_inst, ID_valid, flush_id, ext_stall,
        input  stall, EXE_wraddr, EXE_wr_en, EXE_is_load,
               MEM_wraddr, MEM_wr_en, MEM_is_load, WB_wraddr, WB_wr_en, stall_count
    );

    modport slave (
        input  ID_inst, ID_valid, flush_id, ext_stall,
        output stall, EXE_wraddr, EXE_wr_en, EXE_is_load,
               MEM_wraddr, MEM_wr_en, MEM_is_load, WB_wraddr, WB_wr_en, stall_count
    );
endinterface

// File: rtl/wb_dest_tracker.sv
// wb_dest_tracker: carries ID destination registers through EXE/MEM/WB and stalls ID on load-use hazards
module wb_dest_tracker #(
    parameter int STALL_CNT_W  = 16,
    parameter bit LOAD_USE_MEM = 1'b0
) (
    input logic              clk,
    input logic              rst,
    wb_dest_tracker_if.slave bus
);
    logic [5:0]             opcode, func;
    logic [4:0]             rs, rt, rd;
    logic [4:0]             dec_addr;
    logic                   dec_wr, dec_load;
    logic                   rs_rd, rt_rd;
    logic                   hz_exe, hz_mem, hz, bubble;
    logic [4:0]             exe_addr, mem_addr, wb_addr;
    logic                   exe_wr, exe_load, mem_wr, mem_load, wb_wr;
    logic [STALL_CNT_W-1:0] stall_cnt;

    assign opcode = bus.ID_inst[31:26];
    assign rs     = bus.ID_inst[25:21];
    assign rt     = bus.ID_inst[20:16];
    assign rd     = bus.ID_inst[15:11];
    assign func   = bus.ID_inst[5:0];

    always_comb begin
        dec_addr = 5'd0;
        dec_wr   = 1'b0;
        dec_load = 1'b0;
        case (opcode)
            6'h00: begin
                dec_addr = rd;
                dec_wr   = func != 6'h08;
            end
            6'h08, 6'h0a: begin
                dec_addr = rt;
                dec_wr   = 1'b1;
            end
            6'h23: begin
                dec_addr = rt;
                dec_wr   = 1'b1;
                dec_load = 1'b1;
            end
            6'h03: begin
                dec_addr = 5'd31;
                dec_wr   = 1'b1;
            end
            default: ;
        endcase
        // $0 is never written, so a $0 destination collapses to a bubble-like record
        if (dec_addr == 5'd0 || !dec_wr) begin
            dec_addr = 5'd0;
            dec_wr   = 1'b0;
            dec_load = 1'b0;
        end
    end

    assign rs_rd = !((opcode == 6'h00 && (func == 6'h00 || func == 6'h02)) ||
                     opcode == 6'h02 || opcode == 6'h03);
    assign rt_rd = (opcode == 6'h00 && func != 6'h08) ||
                   opcode == 6'h2b || opcode == 6'h04 || opcode == 6'h05;

    // wr_en already implies a nonzero address, so $0 sources can never match
    assign hz_exe = exe_wr && exe_load &&
                    ((rs_rd && rs == exe_addr) || (rt_rd && rt == exe_addr));
    assign hz_mem = LOAD_USE_MEM && mem_wr && mem_load &&
                    ((rs_rd && rs == mem_addr) || (rt_rd && rt == mem_addr));
    assign hz     = bus.ID_valid && !bus.flush_id && (hz_exe || hz_mem);
    assign bubble = hz || bus.flush_id || !bus.ID_valid;

    assign bus.stall = hz && !bus.ext_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_addr  <= 5'd0;
            exe_wr    <= 1'b0;
            exe_load  <= 1'b0;
            mem_addr  <= 5'd0;
            mem_wr    <= 1'b0;
            mem_load  <= 1'b0;
            wb_addr   <= 5'd0;
            wb_wr     <= 1'b0;
            stall_cnt <= '0;
        end else if (!bus.ext_stall) begin
            wb_addr  <= mem_addr;
            wb_wr    <= mem_wr;
            mem_addr <= exe_addr;
            mem_wr   <= exe_wr;
            mem_load <= exe_load;
            exe_addr <= bubble ? 5'd0 : dec_addr;
            exe_wr   <= bubble ? 1'b0 : dec_wr;
            exe_load <= bubble ? 1'b0 : dec_load;
            if (hz && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.EXE_wraddr  = exe_addr;
    assign bus.EXE_wr_en   = exe_wr;
    assign bus.EXE_is_load = exe_load;
    assign bus.MEM_wraddr  = mem_addr;
    assign bus.MEM_wr_en   = mem_wr;
    assign bus.MEM_is_load = mem_load;
    assign bus.WB_wraddr   = wb_addr;
    assign bus.WB_wr_en    = wb_wr;
    assign bus.stall_count = stall_cnt;
endmodule

// File: doc/wb_dest_tracker.md
Name: wb_dest_tracker

Overview:
Producer-side companion to the ID-stage forwarding logic in the 5-stage MIPS pipeline. Decodes the destination register of each instruction leaving ID and carries it through EXE, MEM and WB shadow registers. From these it drives the per-stage write address and write-enable buses that the forwarding logic consumes. It also detects load-use hazards that forwarding cannot resolve, stalls ID/IF, and inserts bubbles. It counts stall cycles for performance monitoring.

Parameters:
STALL_CNT_W, 16, width of saturating stall-cycle counter
LOAD_USE_MEM, 0, if 1 also stall when ID reads a register being loaded by an LW in MEM (slow data memory)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
ID_inst  input  32  instruction currently in ID
ID_valid  input  1  ID holds a real instruction (0 = bubble)
flush_id  input  1  taken branch/jump; ID instruction discarded this cycle
ext_stall  input  1  global freeze (memory busy); all tracker state holds
stall  output  1  hold PC and IF/ID register this cycle (load-use)
EXE_wraddr  output  5  destination reg of instruction in EXE
EXE_wr_en  output  1  EXE instruction writes the register file
EXE_is_load  output  1  EXE instruction is LW
MEM_wraddr  output  5  destination in MEM
MEM_wr_en  output  1  MEM instruction writes
MEM_is_load  output  1  MEM instruction is LW
WB_wraddr  output  5  destination in WB
WB_wr_en  output  1  WB instruction writes
stall_count  output  STALL_CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (async, rst=1): all wraddr=0, all wr_en=0, all is_load=0, stall_count=0. stall is combinational and is 0 because the is_load flags are 0.
- Destination decode (opcode=inst[31:26], func=inst[5:0]):
  - opcode 0x00: dest=rd, wr=1, except func 0x08 (JR), which gives wr=0.
  - ADDI 0x08, SLTI 0x0a: dest=rt, wr=1.
  - LW 0x23: dest=rt, wr=1, load=1.
  - JAL 0x03: dest=31, wr=1.
  - SW 0x2b, BEQ 0x04, BNE 0x05, J 0x02: wr=0.
  - Any other opcode: wr=0.
  - A dest of 0 forces wr=0. When wr=0, dest is recorded as 0.
- Source decode (for hazard detection):
  - rs is read unless R-type SLL/SRL (func 0x00/0x02) or J/JAL.
  - rt is read for R-type other than JR, and for SW/BEQ/BNE.
  - A source of register 0 never hazards.
- Hazard (combinational): hz = ID_valid & ~flush_id & (a read source == EXE_wraddr & EXE_wr_en & EXE_is_load). When LOAD_USE_MEM=1, hz also asserts on the same match against the MEM-stage fields. stall = hz & ~ext_stall.
- Stage update at each rising clk when rst=0:
  - ext_stall=1: every register holds; stall_count holds.
  - Otherwise WB <= MEM and MEM <= EXE, with the load flag dropping on entry to WB.
  - EXE receives a bubble (wr_en=0, addr=0, load=0) if hz, flush_id or ~ID_valid. Otherwise EXE receives the decoded ID fields.
- Latency: decoded destination appears on EXE_* one cycle after ID presents it, on MEM_* after two, on WB_* after three (without freezes).
- LW followed immediately by a dependent use gives exactly one stall cycle with LOAD_USE_MEM=0, and two with LOAD_USE_MEM=1.
- stall_count increments by 1 in each cycle where stall=1. It saturates at all-ones and does not wrap.
- Simultaneous flush_id and hazard: flush wins; stall=0 and EXE gets a bubble.
- Reset asserted mid-stall clears the stage registers at once, so stall drops in the same cycle.

Test Plan:
1. Reset, then ID_inst=0x010B5020 (add $10,$8,$11), ID_valid=1 -> EXE_wraddr=10/EXE_wr_en=1 next cycle; MEM the cycle after; WB the third cycle; stall never asserts.
2. LW 0x8D280000 (lw $8,0($9)) then 0x010B5020 held in ID -> stall=1 for exactly one cycle; EXE bubble (wr_en=0) that cycle; stall_count=1; add enters EXE on the following cycle.
3. Same sequence with LOAD_USE_MEM=1 -> two stall cycles; stall_count=2.
4. LW $8 in EXE, ID=0x8D280000-dependent instruction with flush_id=1 -> stall=0; EXE next cycle is a bubble.
5. JAL 0x0C000010 -> EXE_wraddr=31/wr_en=1. Each of SW 0xAD280000, BEQ 0x11090003, JR 0x01000008 and ADDI to $0 0x20000005 -> wr_en=0, addr=0.
6. ext_stall=1 for 3 cycles during a load-use hazard -> all stage outputs frozen, stall=0, counter unchanged. Separately, preload the counter to all-ones via repeated hazards -> it stays all-ones.
